// File: rtl/operand_fetch_sb.sv
// operand_fetch_sb
//   Operand-fetch / issue stage between decode and execute. Extracts the
//   immediate, muxes the three operand slots, and keeps a DEPTH-entry lock
//   queue of in-flight register writes. An instruction is held off (o_ready=0)
//   on a read-after-write hit in the queue or on a load while a store is in
//   flight. The queue tail drives the register-file writeback strobe.
//
// Ports
//   i_clk, i_rstn               clock, synchronous active-low reset
//   i_valid / o_ready           decode -> stage handshake (o_ready = issue)
//   i_rs1, i_rs2, i_rd, i_rd_we register addresses and write flag
//   i_is_load, i_is_store       memory read / write markers
//   i_instr_format, i_instr     format code and raw word for the immediate
//   i_next_pc                   PC operand (U/J formats)
//   i_instr_type, i_alu_sel     control passed through to execute
//   i_tag                       instruction tag passed through
//   i_data_rs1, i_data_rs2      register-file read data
//   i_wb_data                   writeback data of the retiring tail entry
//   o_rs1_add, o_rs2_add        register-file read addresses
//   o_valid / i_ready           stage -> execute handshake
//   o_opA, o_opB, o_opC         operands
//   o_next_pc, o_instr_type, o_alu_sel, o_tag   registered pass-through
//   o_addr_wr, o_wr_en          writeback address and strobe

module operand_fetch_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 2,
  parameter int TAGW  = 4,
  parameter int FWD   = 0,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [AW-1:0]   i_rs1,
  input  logic [AW-1:0]   i_rs2,
  input  logic [AW-1:0]   i_rd,
  input  logic            i_rd_we,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_instr_format,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic [2:0]      i_instr_type,
  input  logic [2:0]      i_alu_sel,
  input  logic [TAGW-1:0] i_tag,
  input  logic [XLEN-1:0] i_data_rs1,
  input  logic [XLEN-1:0] i_data_rs2,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [AW-1:0]   o_rs1_add,
  output logic [AW-1:0]   o_rs2_add,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_opA,
  output logic [XLEN-1:0] o_opB,
  output logic [XLEN-1:0] o_opC,
  output logic [XLEN-1:0] o_next_pc,
  output logic [2:0]      o_instr_type,
  output logic [2:0]      o_alu_sel,
  output logic [TAGW-1:0] o_tag,
  output logic [AW-1:0]   o_addr_wr,
  output logic            o_wr_en
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] OP0    = 3'd0;
  localparam logic [2:0] BYPASS = 3'd0;

  // lock queue: entry 0 is the youngest, entry DEPTH-1 is the tail
  logic [DEPTH-1:0] qv_q, qv_d, qst_q, qst_d;
  logic [AW-1:0]    qrd_q [DEPTH];
  logic [AW-1:0]    qrd_d [DEPTH];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, opc_q, opc_d, pc_q, pc_d;
  logic [2:0]      type_q, type_d, alu_q, alu_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic            adv, issue, mem_haz;
  logic            rs1_young, rs1_tail, rs2_young, rs2_tail;
  logic            fwd1, fwd2, raw1, raw2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, opa_n, opb_n, opc_n;

  logic unused_instr;
  assign unused_instr = ^i_instr[6:0];

  assign adv = !valid_q || i_ready;

  always_comb begin
    rs1_young = 1'b0;
    rs2_young = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (qv_q[i] && (qrd_q[i] == i_rs1)) rs1_young = 1'b1;
      if (qv_q[i] && (qrd_q[i] == i_rs2)) rs2_young = 1'b1;
    end
    rs1_tail = qv_q[DEPTH-1] && (qrd_q[DEPTH-1] == i_rs1);
    rs2_tail = qv_q[DEPTH-1] && (qrd_q[DEPTH-1] == i_rs2);
    if (i_rs1 == '0) begin
      rs1_young = 1'b0;
      rs1_tail  = 1'b0;
    end
    if (i_rs2 == '0) begin
      rs2_young = 1'b0;
      rs2_tail  = 1'b0;
    end
    // a tail hit is only forwardable when the tail actually retires this cycle;
    // any younger hit carries the newer value and must stall
    fwd1 = (FWD != 0) && adv && rs1_tail && !rs1_young;
    fwd2 = (FWD != 0) && adv && rs2_tail && !rs2_young;
    raw1 = rs1_young || (rs1_tail && !fwd1);
    raw2 = rs2_young || (rs2_tail && !fwd2);
  end

  assign mem_haz = i_is_load && (|qst_q);
  // reset gates issue so nothing is accepted while the queue is being cleared
  assign issue   = i_rstn && i_valid && adv && !raw1 && !raw2 && !mem_haz;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (i_rs1 != '0) rs1_val = fwd1 ? i_wb_data : i_data_rs1;
    if (i_rs2 != '0) rs2_val = fwd2 ? i_wb_data : i_data_rs2;
  end

  always_comb begin
    imm = '0;
    unique case (i_instr_format)
      FMT_I:   imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      FMT_S:   imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U:   imm = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
      FMT_J:   imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    opa_n = '0;
    opb_n = '0;
    opc_n = '0;
    unique case (i_instr_format)
      FMT_I: begin opa_n = rs1_val;   opb_n = imm;                   end
      FMT_S: begin opa_n = rs1_val;   opb_n = imm;     opc_n = rs2_val; end
      FMT_R: begin opa_n = rs1_val;   opb_n = rs2_val;               end
      FMT_B: begin opa_n = rs1_val;   opb_n = rs2_val; opc_n = imm;  end
      FMT_U,
      FMT_J: begin opa_n = i_next_pc; opb_n = imm;                   end
      default: ;
    endcase
  end

  always_comb begin
    qv_d    = qv_q;
    qst_d   = qst_q;
    qrd_d   = qrd_q;
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    pc_d    = pc_q;
    type_d  = type_q;
    alu_d   = alu_q;
    tag_d   = tag_q;
    if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        qv_d[i]  = qv_q[i-1];
        qst_d[i] = qst_q[i-1];
        qrd_d[i] = qrd_q[i-1];
      end
      qv_d[0]  = issue && i_rd_we && (i_rd != '0);
      qst_d[0] = issue && i_is_store;
      qrd_d[0] = issue ? i_rd : '0;

      valid_d = 1'b0;
      opa_d   = '0;
      opb_d   = '0;
      opc_d   = '0;
      pc_d    = '0;
      type_d  = OP0;
      alu_d   = BYPASS;
      tag_d   = '0;
      if (issue) begin
        valid_d = 1'b1;
        opa_d   = opa_n;
        opb_d   = opb_n;
        opc_d   = opc_n;
        pc_d    = i_next_pc;
        type_d  = i_instr_type;
        alu_d   = i_alu_sel;
        tag_d   = i_tag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      qv_q    <= '0;
      qst_q   <= '0;
      for (int i = 0; i < DEPTH; i++) qrd_q[i] <= '0;
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      pc_q    <= '0;
      type_q  <= OP0;
      alu_q   <= BYPASS;
      tag_q   <= '0;
    end else begin
      qv_q    <= qv_d;
      qst_q   <= qst_d;
      qrd_q   <= qrd_d;
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      pc_q    <= pc_d;
      type_q  <= type_d;
      alu_q   <= alu_d;
      tag_q   <= tag_d;
    end
  end

  assign o_ready      = issue;
  assign o_rs1_add    = i_rs1;
  assign o_rs2_add    = i_rs2;
  assign o_valid      = valid_q;
  assign o_opA        = opa_q;
  assign o_opB        = opb_q;
  assign o_opC        = opc_q;
  assign o_next_pc    = pc_q;
  assign o_instr_type = type_q;
  assign o_alu_sel    = alu_q;
  assign o_tag        = tag_q;
  assign o_addr_wr    = qrd_q[DEPTH-1];
  // no strobe while reset is asserted: in-flight writes are being discarded
  assign o_wr_en      = i_rstn && adv && qv_q[DEPTH-1];

endmodule
